// File: rtl/pipe_issue_ctrl.sv
// Issue controller: instruction FIFO, RAW scoreboard with bubble insertion,
// flush/drain sequencing and issue/stall counters.
module pipe_issue_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int PIPE_DEPTH = 3,
    parameter int REG_AW     = 4,
    parameter int FUNC_W     = 4,
    parameter int MEM_AW     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [FUNC_W-1:0] in_func,
    input  logic [MEM_AW-1:0] in_addr,
    input  logic              flush,
    output logic              iss_valid,
    output logic [REG_AW-1:0] iss_rs1,
    output logic [REG_AW-1:0] iss_rs2,
    output logic [REG_AW-1:0] iss_rd,
    output logic [FUNC_W-1:0] iss_func,
    output logic [MEM_AW-1:0] iss_addr,
    output logic              busy,
    output logic [15:0]       issue_cnt,
    output logic [15:0]       stall_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [FUNC_W-1:0] func;
        logic [MEM_AW-1:0] addr;
    } instr_t;

    instr_t                fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [1:0]            state_reg;
    logic [1:0]            state_next;
    logic [PIPE_DEPTH-1:0] sb_v_reg;
    logic [PIPE_DEPTH-1:0] sb_v_next;
    logic [PIPE_DEPTH-1:0] hazard_vec;
    logic [REG_AW-1:0]     sb_rd_reg  [PIPE_DEPTH];
    logic [REG_AW-1:0]     sb_rd_next [PIPE_DEPTH];
    instr_t                head;
    instr_t                in_instr;
    instr_t                iss_reg;
    logic                  iss_valid_reg;
    logic [15:0]           issue_cnt_reg;
    logic [15:0]           stall_cnt_reg;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic issue;
    logic stall;
    logic hazard;
    logic fifo_clear;
    logic sb_drained;

    assign in_instr   = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};
    assign head       = fifo_mem[rd_ptr_reg];
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign in_ready   = !fifo_full && (state_reg != ST_DRAIN);
    assign push       = in_valid && in_ready;
    assign hazard     = |hazard_vec;

    // A flush in the same cycle as an otherwise legal issue suppresses that issue.
    assign fifo_clear = (state_reg == ST_RUN) && flush;
    assign issue      = (state_reg == ST_RUN) && !fifo_empty && !hazard && !flush;
    assign stall      = (state_reg == ST_RUN) && !fifo_empty && hazard;

    // Scoreboard shifts every cycle; slot k holds the rd issued k+1 cycles ago.
    genvar gi;
    generate
        for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_sb
            assign hazard_vec[gi] = sb_v_reg[gi] &&
                                    ((head.rs1 == sb_rd_reg[gi]) || (head.rs2 == sb_rd_reg[gi]));
            if (gi == 0) begin : g_head
                assign sb_v_next[gi]  = issue;
                assign sb_rd_next[gi] = head.rd;
            end else begin : g_shift
                assign sb_v_next[gi]  = sb_v_reg[gi-1];
                assign sb_rd_next[gi] = sb_rd_reg[gi-1];
            end
        end
    endgenerate

    // Empty after this edge, so busy falls PIPE_DEPTH cycles after the last issue.
    assign sb_drained = ~|sb_v_next;

    always_ff @(posedge clk) begin
        if (push && !fifo_clear) begin
            fifo_mem[wr_ptr_reg] <= in_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (fifo_clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (issue) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(issue);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_v_reg <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                sb_rd_reg[i] <= '0;
            end
        end else begin
            sb_v_reg <= sb_v_next;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                sb_rd_reg[i] <= sb_rd_next[i];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (push) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_next = ST_DRAIN;
                end else if (fifo_empty && !push && sb_drained) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (sb_drained) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            iss_valid_reg <= 1'b0;
            iss_reg       <= '0;
            issue_cnt_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            iss_valid_reg <= issue;
            if (issue) begin
                iss_reg       <= head;
                issue_cnt_reg <= issue_cnt_reg + 16'd1;
            end
            if (stall && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
        end
    end

    assign iss_valid = iss_valid_reg;
    assign iss_rs1   = iss_reg.rs1;
    assign iss_rs2   = iss_reg.rs2;
    assign iss_rd    = iss_reg.rd;
    assign iss_func  = iss_reg.func;
    assign iss_addr  = iss_reg.addr;
    assign busy      = (state_reg != ST_IDLE);
    assign issue_cnt = issue_cnt_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Directed bench for pipe_issue_ctrl: per-cycle vector table for streaming and
// RAW bubbles, then hand sequences for full FIFO, flush/drain and async reset.
module tb_pipe_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_rs1, in_rs2, in_rd, in_func;
    logic [7:0] in_addr;
    logic       flush;
    logic       iss_valid;
    logic [3:0] iss_rs1, iss_rs2, iss_rd, iss_func;
    logic [7:0] iss_addr;
    logic       busy;
    logic [15:0] issue_cnt, stall_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pipe_issue_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_func   (in_func),
        .in_addr   (in_addr),
        .flush     (flush),
        .iss_valid (iss_valid),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_func  (iss_func),
        .iss_addr  (iss_addr),
        .busy      (busy),
        .issue_cnt (issue_cnt),
        .stall_cnt (stall_cnt)
    );

    typedef struct {
        logic        v;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rd;
        logic [3:0]  func;
        logic [7:0]  addr;
        logic        fl;
        logic        e_iv;
        logic [3:0]  e_rd;
        logic [3:0]  e_func;
        logic [7:0]  e_addr;
        logic        e_rdy;
        logic        e_busy;
        logic [15:0] e_icnt;
        logic [15:0] e_scnt;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic [3:0] rd, input logic [3:0] func,
                         input logic [7:0] addr, input logic fl);
        in_valid = v;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
        in_func  = func;
        in_addr  = addr;
        flush    = fl;
    endtask

    task automatic idle_in(input logic fl);
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00, fl);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check(name, 64'(busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] act;
        logic [63:0] exp;

        // T2 independent stream then T3 RAW dependency, one row per clock edge.
        //           v     rs1   rs2   rd    func  addr   fl    iv    rd    func  addr   rdy   busy  icnt    scnt
        vecs[0]  = '{1'b1, 4'd1, 4'd2, 4'd0, 4'd1, 8'h10, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 1'b1, 1'b1, 16'd0, 16'd0};
        vecs[1]  = '{1'b1, 4'd4, 4'd5, 4'd3, 4'd2, 8'h11, 1'b0, 1'b1, 4'd0, 4'd1, 8'h10, 1'b1, 1'b1, 16'd1, 16'd0};
        vecs[2]  = '{1'b1, 4'd7, 4'd8, 4'd6, 4'd3, 8'h12, 1'b0, 1'b1, 4'd3, 4'd2, 8'h11, 1'b1, 1'b1, 16'd2, 16'd0};
        vecs[3]  = '{1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd6, 4'd3, 8'h12, 1'b1, 1'b1, 16'd3, 16'd0};
        vecs[4]  = '{1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd6, 4'd3, 8'h12, 1'b1, 1'b1, 16'd3, 16'd0};
        vecs[5]  = '{1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd6, 4'd3, 8'h12, 1'b1, 1'b1, 16'd3, 16'd0};
        vecs[6]  = '{1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd6, 4'd3, 8'h12, 1'b1, 1'b0, 16'd3, 16'd0};
        vecs[7]  = '{1'b1, 4'd2, 4'd3, 4'd1, 4'd4, 8'h20, 1'b0, 1'b0, 4'd6, 4'd3, 8'h12, 1'b1, 1'b1, 16'd3, 16'd0};
        vecs[8]  = '{1'b1, 4'd1, 4'd9, 4'd4, 4'd5, 8'h21, 1'b0, 1'b1, 4'd1, 4'd4, 8'h20, 1'b1, 1'b1, 16'd4, 16'd0};
        vecs[9]  = '{1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd1, 4'd4, 8'h20, 1'b1, 1'b1, 16'd4, 16'd1};
        vecs[10] = '{1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd1, 4'd4, 8'h20, 1'b1, 1'b1, 16'd4, 16'd2};
        vecs[11] = '{1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd1, 4'd4, 8'h20, 1'b1, 1'b1, 16'd4, 16'd3};
        vecs[12] = '{1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd4, 4'd5, 8'h21, 1'b1, 1'b1, 16'd5, 16'd3};

        // T1 reset state, no clock edge seen yet
        rst_n = 1'b0;
        idle_in(1'b0);
        #2;
        check("t1_iss_valid", 64'(iss_valid), 64'd0);
        check("t1_busy",      64'(busy),      64'd0);
        check("t1_in_ready",  64'(in_ready),  64'd1);
        check("t1_issue_cnt", 64'(issue_cnt), 64'd0);
        check("t1_stall_cnt", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].func,
                  vecs[i].addr, vecs[i].fl);
            tick();
            act = {13'd0, iss_valid, iss_rd, iss_func, iss_addr, in_ready, busy, issue_cnt, stall_cnt};
            exp = {13'd0, vecs[i].e_iv, vecs[i].e_rd, vecs[i].e_func, vecs[i].e_addr,
                   vecs[i].e_rdy, vecs[i].e_busy, vecs[i].e_icnt, vecs[i].e_scnt};
            $display("[TB] vec %0d: iss_valid=%0b rd=%0d busy=%0b issue_cnt=%0d stall_cnt=%0d",
                     i, iss_valid, iss_rd, busy, issue_cnt, stall_cnt);
            check($sformatf("vec%0d", i), act, exp);
        end
        check("t3_iss_rs1", 64'(iss_rs1), 64'd1);
        check("t3_iss_rs2", 64'(iss_rs2), 64'd9);
        idle_in(1'b0);
        wait_idle("t3_idle");

        // T4: producer rd=5 blocks four dependents until the FIFO fills
        drive(1'b1, 4'd0, 4'd0, 4'd5,  4'd0, 8'h50, 1'b0); tick();
        drive(1'b1, 4'd5, 4'd0, 4'd10, 4'd0, 8'h51, 1'b0); tick();
        check("t4_prod_issue", {iss_valid, iss_rd}, {1'b1, 4'd5});
        drive(1'b1, 4'd5, 4'd0, 4'd11, 4'd0, 8'h52, 1'b0); tick();
        drive(1'b1, 4'd5, 4'd0, 4'd12, 4'd0, 8'h53, 1'b0); tick();
        drive(1'b1, 4'd5, 4'd0, 4'd13, 4'd0, 8'h54, 1'b0); tick();
        check("t4_full_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 4'd0, 4'd0, 4'd14, 4'd0, 8'h55, 1'b0); tick();
        check("t4_d1_issue", {iss_valid, iss_rd}, {1'b1, 4'd10});
        check("t4_ready_after_pop", 64'(in_ready), 64'd1);
        idle_in(1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            $display("[TB] t4 drain %0d: iss_valid=%0b rd=%0d", k, iss_valid, iss_rd);
            check($sformatf("t4_d%0d_issue", k + 2), {iss_valid, iss_rd}, {1'b1, 4'(11 + k)});
        end
        tick();
        check("t4_fifth_dropped", 64'(iss_valid), 64'd0);
        check("t4_issue_cnt", 64'(issue_cnt), 64'd10);
        check("t4_stall_cnt", 64'(stall_cnt), 64'd6);
        wait_idle("t4_idle");

        // T5: flush with three queued and two in flight; head issuable at flush edge
        drive(1'b1, 4'd0, 4'd0, 4'd1, 4'd0, 8'h60, 1'b0); tick();
        drive(1'b1, 4'd1, 4'd1, 4'd2, 4'd0, 8'h61, 1'b0); tick();
        drive(1'b1, 4'd0, 4'd0, 4'd3, 4'd0, 8'h62, 1'b0); tick();
        drive(1'b1, 4'd0, 4'd0, 4'd4, 4'd0, 8'h63, 1'b0); tick();
        drive(1'b1, 4'd0, 4'd0, 4'd5, 4'd0, 8'h64, 1'b0); tick();
        idle_in(1'b0); tick();
        check("t5_x1_issue", {iss_valid, iss_rd}, {1'b1, 4'd2});
        drive(1'b1, 4'd0, 4'd0, 4'd6, 4'd0, 8'h65, 1'b0); tick();
        check("t5_x2_issue", {iss_valid, iss_rd}, {1'b1, 4'd3});
        drive(1'b1, 4'd0, 4'd0, 4'd7, 4'd0, 8'h66, 1'b1); tick();
        check("t5_flush_no_issue", {iss_valid, busy, in_ready}, {1'b0, 1'b1, 1'b0});
        idle_in(1'b1); tick();
        check("t5_drain_hold", {iss_valid, busy, in_ready}, {1'b0, 1'b1, 1'b0});
        idle_in(1'b0); tick();
        check("t5_drain_done", {iss_valid, busy, in_ready}, {1'b0, 1'b0, 1'b1});
        check("t5_issue_cnt", 64'(issue_cnt), 64'd13);
        check("t5_stall_cnt", 64'(stall_cnt), 64'd9);
        idle_in(1'b1); tick();
        check("t5_flush_in_idle", {busy, in_ready}, {1'b0, 1'b1});
        drive(1'b1, 4'd0, 4'd0, 4'd9, 4'd2, 8'h40, 1'b0); tick();
        idle_in(1'b0); tick();
        check("t5_restart_issue", {iss_valid, iss_rd, iss_addr}, {1'b1, 4'd9, 8'h40});
        check("t5_restart_cnt", 64'(issue_cnt), 64'd14);
        tick();
        check("t5_no_stale", 64'(iss_valid), 64'd0);
        wait_idle("t5_idle");

        // T6: asynchronous reset while a dependent is stalled
        drive(1'b1, 4'd0, 4'd0, 4'd7, 4'd0, 8'h70, 1'b0); tick();
        drive(1'b1, 4'd7, 4'd7, 4'd8, 4'd0, 8'h71, 1'b0); tick();
        check("t6_prod_issue", {iss_valid, iss_rd, issue_cnt}, {1'b1, 4'd7, 16'd15});
        idle_in(1'b0); tick();
        check("t6_stalling", 64'(stall_cnt), 64'd10);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_clear", {iss_valid, iss_rd, busy, in_ready, issue_cnt, stall_cnt},
              {1'b0, 4'd0, 1'b0, 1'b1, 16'd0, 16'd0});
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'd0, 4'd0, 4'd2, 4'd0, 8'h30, 1'b0); tick();
        drive(1'b1, 4'd0, 4'd0, 4'd3, 4'd0, 8'h31, 1'b0); tick();
        check("t6_f_issue", {iss_valid, iss_rd, issue_cnt}, {1'b1, 4'd2, 16'd1});
        idle_in(1'b0); tick();
        check("t6_g_issue", {iss_valid, iss_rd, issue_cnt}, {1'b1, 4'd3, 16'd2});
        tick();
        check("t6_old_gone", {iss_valid, stall_cnt}, {1'b0, 16'd0});
        wait_idle("t6_idle");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
